// File: rtl/my_mux.sv
// my_mux: registered 4:1 selector with sample enable, output-valid strobe and
// a sticky error flag for captures made with a nonzero reserved select field.
// WIDTH must be at least 2: Sel[1:0] is always the source index.
module my_mux #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] SWa,
  input  logic [WIDTH-1:0] SWb,
  input  logic [WIDTH-1:0] SWc,
  input  logic [WIDTH-1:0] SWd,
  input  logic [WIDTH-1:0] Sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sel_err
);

  logic             rsv_nz;
  logic [WIDTH-1:0] selected;

  // Reserved field is Sel[WIDTH-1:2]; it does not exist when WIDTH is 2.
  if (WIDTH > 2) begin : g_rsv
    assign rsv_nz = |Sel[WIDTH-1:2];
  end else begin : g_no_rsv
    assign rsv_nz = 1'b0;
  end

  // Source decode; only the indexed source reaches the register, so X/Z on
  // the other three cannot leak into out.
  always_comb begin
    selected = '0;
    unique case (Sel[1:0])
      2'd0: selected = SWa;
      2'd1: selected = SWb;
      2'd2: selected = SWc;
      2'd3: selected = SWd;
      default: selected = '0;
    endcase
  end

  // Capture register: load on en, hold otherwise; out_valid mirrors en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        out     <= rsv_nz ? '0 : selected;
        sel_err <= rsv_nz;
      end
    end
  end

endmodule

// File: tb/tb_my_mux.sv
// Self-checking bench for my_mux: one WIDTH=2 and one WIDTH=4 instance.
module tb_my_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, c2 = '0, d2 = '0, sel2 = '0;
  logic [1:0] out2;
  logic       v2, err2;

  logic       en4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, c4 = '0, d4 = '0, sel4 = '0;
  logic [3:0] out4;
  logic       v4, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_mux #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .SWa(a2), .SWb(b2), .SWc(c2), .SWd(d2), .Sel(sel2),
    .out(out2), .out_valid(v2), .sel_err(err2)
  );

  my_mux #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4),
    .SWa(a4), .SWb(b4), .SWc(c4), .SWd(d4), .Sel(sel4),
    .out(out4), .out_valid(v4), .sel_err(err4)
  );

  typedef struct {
    bit       en;
    bit [3:0] sel, a, b, c, d;
    bit [3:0] exp_out;
    bit       exp_v, exp_err;
  } vec_t;

  vec_t vecs[8];

  // Reference: four sources in an array, index by select value; any select
  // of 4 or more has a reserved bit set and yields zero.
  function automatic logic [3:0] ref_pick(input logic [3:0] a, b, c, d,
                                          input logic [3:0] s);
    logic [3:0] srcs[4];
    srcs = '{a, b, c, d};
    if (s >= 4) return 4'h0;
    return srcs[s];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m_out2, m_out4;
    logic       m_v2, m_v4, m_err4;

    vecs[0] = '{1, 4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 1, 1};
    vecs[1] = '{1, 4'h1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA, 1, 0};
    vecs[2] = '{0, 4'h2, 4'h0, 4'h0, 4'h7, 4'h0, 4'hA, 0, 0};
    vecs[3] = '{1, 4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1, 0};
    vecs[4] = '{1, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1, 1};
    vecs[5] = '{0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1};
    vecs[6] = '{1, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h3, 1, 0};
    vecs[7] = '{1, 4'h2, 4'h0, 4'h0, 4'h9, 4'h0, 4'h9, 1, 0};

    // Reset state, then first capture only with en.
    #3;
    chk("rst_out2", out2, 0);
    chk("rst_v2", v2, 0);
    chk("rst_out4", out4, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle_out2", out2, 0);
    chk("post_rst_idle_v2", v2, 0);

    // Select sweep on WIDTH=2.
    a2 = 2'd0; b2 = 2'd1; c2 = 2'd2; d2 = 2'd3; en2 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel2 = s[1:0];
      chk("sweep_pre_out2", out2, (s == 0) ? 0 : s - 1);
      step();
      chk($sformatf("sweep_out2_%0d", s), out2, s);
      chk($sformatf("sweep_v2_%0d", s), v2, 1);
    end

    // Asynchronous reset while out holds 3.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out2", out2, 0);
    chk("async_rst_v2", v2, 0);
    chk("async_rst_err2", err2, 0);
    step();
    chk("rst_held_out2", out2, 0);
    #2;
    rst_n = 1'b1;

    // Hold: capture Sel=2, then en=0 with everything changed.
    sel2 = 2'd2; c2 = 2'd2; en2 = 1'b1;
    step();
    chk("hold_cap_out2", out2, 2);
    en2 = 1'b0; sel2 = 2'd1; a2 = 2'd3; b2 = 2'd3; c2 = 2'd0; d2 = 2'd1;
    step();
    chk("hold_out2", out2, 2);
    chk("hold_v2", v2, 0);
    step();
    chk("hold2_out2", out2, 2);

    // Mid-cycle change of the selected source.
    sel2 = 2'd1; b2 = 2'd1; en2 = 1'b1;
    step();
    chk("glitch_cap_out2", out2, 1);
    #3;
    b2 = 2'd2;
    #1;
    chk("glitch_mid_out2", out2, 1);
    step();
    chk("glitch_edge_out2", out2, 2);

    // Table vectors on WIDTH=4, including reserved-select behaviour.
    for (int i = 0; i < 8; i++) begin
      en4 = vecs[i].en; sel4 = vecs[i].sel;
      a4 = vecs[i].a; b4 = vecs[i].b; c4 = vecs[i].c; d4 = vecs[i].d;
      step();
      chk($sformatf("vec%0d_out4", i), out4, vecs[i].exp_out);
      chk($sformatf("vec%0d_v4", i), v4, vecs[i].exp_v);
      chk($sformatf("vec%0d_err4", i), err4, vecs[i].exp_err);
    end

    // Randomised run against the reference model on both instances.
    m_out2 = {2'b0, out2}; m_out4 = out4; m_err4 = err4;
    for (int i = 0; i < 60; i++) begin
      en2 = ($urandom_range(0, 3) != 0);
      en4 = ($urandom_range(0, 3) != 0);
      {a2, b2, c2, d2, sel2} = 10'($urandom);
      {a4, b4, c4, d4} = 16'($urandom);
      sel4 = 4'($urandom);
      if (en2) m_out2 = ref_pick({2'b0, a2}, {2'b0, b2}, {2'b0, c2},
                                 {2'b0, d2}, {2'b0, sel2});
      m_v2 = en2;
      if (en4) begin
        m_out4 = ref_pick(a4, b4, c4, d4, sel4);
        m_err4 = (sel4 >= 4);
      end
      m_v4 = en4;
      step();
      chk($sformatf("rnd%0d_out2", i), out2, m_out2);
      chk($sformatf("rnd%0d_v2", i), v2, m_v2);
      chk($sformatf("rnd%0d_err2", i), err2, 0);
      chk($sformatf("rnd%0d_out4", i), out4, m_out4);
      chk($sformatf("rnd%0d_v4", i), v4, m_v4);
      chk($sformatf("rnd%0d_err4", i), err4, m_err4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_mux.md
MY_MUX -- requirements
Module: my_mux

Interface
REQ-001 Parameter WIDTH, default 2: bit width of every data input, of Sel and of out. WIDTH SHALL be at least 2.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port en, input, 1 bit: sample enable; when high, a new selection is captured on the clock edge.
REQ-005 Port SWa, input, WIDTH bits: data source 0.
REQ-006 Port SWb, input, WIDTH bits: data source 1.
REQ-007 Port SWc, input, WIDTH bits: data source 2.
REQ-008 Port SWd, input, WIDTH bits: data source 3.
REQ-009 Port Sel, input, WIDTH bits: source select; Sel[1:0] picks the source, Sel[WIDTH-1:2] is reserved and must be zero.
REQ-010 Port out, output, WIDTH bits: registered selected data.
REQ-011 Port out_valid, output, 1 bit: high for the cycle after an enabled capture.
REQ-012 Port sel_err, output, 1 bit: registered flag; high when the last enabled capture had a nonzero reserved Sel field.

Function
REQ-013 Select decode: Sel[1:0] = 0, 1, 2, 3 SHALL select SWa, SWb, SWc, SWd respectively.
REQ-014 On a rising clk edge with en=1 and Sel[WIDTH-1:2]=0, out SHALL load the selected source and sel_err SHALL load 0.
REQ-015 On a rising clk edge with en=1 and Sel[WIDTH-1:2]≠0, out SHALL load all-zeros and sel_err SHALL load 1. For WIDTH=2 the reserved field is empty, so this case never occurs.
REQ-016 Latency SHALL be exactly one clock: inputs sampled at edge N appear on out after edge N.
REQ-017 out_valid SHALL be the value of en registered at each rising edge: 1 for one cycle per enabled capture, continuously 1 while en stays high.
REQ-018 With en=0 at a rising edge, out and sel_err SHALL hold their previous values and out_valid SHALL load 0.
REQ-019 Input changes between clock edges SHALL have no effect on outputs. There is no combinational path from any input to any output, except rst_n.
REQ-020 Data SHALL pass bit-exact: no arithmetic, sign extension or truncation.
REQ-021 Inputs SHALL be treated as synchronous to clk. X/Z on unselected sources SHALL NOT propagate to out.

Reset
REQ-022 While rst_n=0, out SHALL be all-zeros, out_valid SHALL be 0 and sel_err SHALL be 0, immediately and independent of clk.
REQ-023 Reset asserted mid-operation SHALL clear all outputs at once and discard any capture in flight.
REQ-024 After rst_n deasserts, the first capture SHALL occur at the first rising edge with en=1. No output SHALL change before then.

Verification
REQ-025 Reset: rst_n=0 while out holds 2'd3 -> out=0, out_valid=0, sel_err=0 without waiting for a clock edge.
REQ-026 Select sweep, WIDTH=2, SWa=0, SWb=1, SWc=2, SWd=3, en=1, Sel stepping 0,1,2,3 on successive edges -> out = 0,1,2,3, each one edge after its Sel; out_valid=1 throughout.
REQ-027 Hold: capture Sel=2 with SWc=2'd2, then en=0 and all inputs changed -> out stays 2, out_valid=0 from the next edge.
REQ-028 Reserved select, WIDTH=4: Sel=4'h5, SWb=4'hA, en=1 -> out=4'h0, sel_err=1. Then Sel=4'h1 -> out=4'hA, sel_err=0.
REQ-029 Randomized: 10+ cycles of random Sel/SWa..SWd with en=1 -> every cycle, out equals the reference mux of the previous edge's inputs.
REQ-030 Mid-glitch: change SWb between edges while Sel=1 -> out changes only at the next rising edge.
